// File: rtl/chess_pkg.sv
// Shared encodings for the board query interface between sequencer and board.
package chess_pkg;

  localparam int unsigned SQ_W    = 6;
  localparam int unsigned PIECE_W = 4;
  localparam int unsigned DATA_W  = SQ_W + 1;

  typedef logic [SQ_W-1:0] square_t;

  typedef enum logic [2:0] {
    SM_IDLE   = 3'd0,
    SM_WRITE  = 3'd1,
    SM_CHECK  = 3'd2,
    SM_VICTIM = 3'd3,
    SM_AGGR   = 3'd4
  } state_mode_t;

  typedef enum logic [1:0] {
    MK_NONE   = 2'd0,
    MK_AGGR   = 2'd1,
    MK_VICTIM = 2'd2,
    MK_CLEAR  = 2'd3
  } mask_mode_t;

  // Piece codes: [3] is colour (1 = black), [2:0] is type, ordered by value.
  localparam logic [PIECE_W-1:0] PC_EMPTY  = 4'h0;
  localparam logic [PIECE_W-1:0] PC_PAWN   = 4'h1;
  localparam logic [PIECE_W-1:0] PC_KNIGHT = 4'h2;
  localparam logic [PIECE_W-1:0] PC_BISHOP = 4'h3;
  localparam logic [PIECE_W-1:0] PC_ROOK   = 4'h4;
  localparam logic [PIECE_W-1:0] PC_QUEEN  = 4'h5;
  localparam logic [PIECE_W-1:0] PC_KING   = 4'h6;
  localparam logic [PIECE_W-1:0] PC_BLACK  = 4'h8;

  // Board arbiter result word.
  typedef struct packed {
    logic    found;
    square_t sq;
  } query_t;

endpackage

// File: rtl/move_sequencer.sv
// Board-query initiator: loads pieces, then walks captures in MVV-LVA order
// and streams them to the search core over valid/ready.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [SQ_W-1:0]   load_sq,
  input  logic [PIECE_W-1:0] load_piece,
  input  logic              gen_start,
  input  logic              gen_wtm,
  input  logic              gen_abort,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [SQ_W-1:0]   move_from,
  output logic [SQ_W-1:0]   move_to,
  output logic              gen_done,
  output logic              pos_illegal,
  output logic [CNT_W-1:0]  move_count,
  output logic [2:0]        state_mode,
  output logic              wtm,
  output logic [PIECE_W-1:0] write_bus,
  output logic [SQ_W-1:0]   ss1,
  output logic [1:0]        mask_mode,
  input  logic [DATA_W-1:0] data_out,
  input  logic              illegal
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_VICTIM = 4'd2,
    S_AGGR   = 4'd3,
    S_EMIT   = 4'd4,
    S_AMASK  = 4'd5,
    S_VMASK  = 4'd6,
    S_DONE   = 4'd7,
    S_CLEAR  = 4'd8
  } fsm_t;

  fsm_t    state;
  square_t victim_q;
  square_t aggr_q;
  logic    wtm_q;
  query_t  q;

  assign q = data_out;

  // Pass sequencing, query result latches, illegal flag and move counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      victim_q    <= '0;
      aggr_q      <= '0;
      wtm_q       <= 1'b0;
      pos_illegal <= 1'b0;
      move_count  <= '0;
    end else if (gen_abort && state != S_IDLE) begin
      state <= S_CLEAR;
    end else begin
      case (state)
        S_IDLE: begin
          if (gen_start && !load_valid) begin
            wtm_q       <= gen_wtm;
            move_count  <= '0;
            pos_illegal <= 1'b0;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          pos_illegal <= illegal;
          state       <= illegal ? S_DONE : S_VICTIM;
        end
        S_VICTIM: begin
          if (q.found) begin
            victim_q <= q.sq;
            state    <= S_AGGR;
          end else begin
            state <= S_DONE;
          end
        end
        S_AGGR: begin
          if (q.found) begin
            aggr_q <= q.sq;
            state  <= S_EMIT;
          end else begin
            state <= S_VMASK;
          end
        end
        S_EMIT: begin
          if (move_ready) begin
            if (move_count != '1) move_count <= move_count + CNT_W'(1);
            state <= S_AMASK;
          end
        end
        S_AMASK: state <= S_AGGR;
        S_VMASK: state <= S_VICTIM;
        S_DONE:  state <= S_IDLE;
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Board command and handshake decode; everything idles while reset is held.
  always_comb begin
    load_ready = 1'b0;
    move_valid = 1'b0;
    move_from  = '0;
    move_to    = '0;
    gen_done   = 1'b0;
    state_mode = SM_IDLE;
    mask_mode  = MK_NONE;
    wtm        = 1'b0;
    write_bus  = '0;
    ss1        = '0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          load_ready = 1'b1;
          if (load_valid) begin
            state_mode = SM_WRITE;
            ss1        = load_sq;
            write_bus  = load_piece;
          end
        end
        S_CHECK: begin
          wtm        = wtm_q;
          state_mode = SM_CHECK;
        end
        S_VICTIM: begin
          wtm        = wtm_q;
          state_mode = SM_VICTIM;
        end
        S_AGGR: begin
          wtm        = wtm_q;
          state_mode = SM_AGGR;
          ss1        = victim_q;
        end
        S_EMIT: begin
          wtm        = wtm_q;
          move_valid = !gen_abort;
          move_from  = aggr_q;
          move_to    = victim_q;
        end
        S_AMASK: begin
          wtm       = wtm_q;
          mask_mode = MK_AGGR;
          ss1       = aggr_q;
        end
        S_VMASK: begin
          wtm       = wtm_q;
          mask_mode = MK_VICTIM;
          ss1       = victim_q;
        end
        S_DONE: begin
          wtm       = wtm_q;
          gen_done  = !gen_abort;
          mask_mode = MK_CLEAR;
        end
        S_CLEAR: begin
          wtm       = wtm_q;
          mask_mode = MK_CLEAR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer with a behavioural 64-square board.
`timescale 1ns/1ps
module tb_move_sequencer;
  import chess_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [5:0]       load_sq = '0;
  logic [3:0]       load_piece = '0;
  logic             gen_start = 1'b0;
  logic             gen_wtm = 1'b0;
  logic             gen_abort = 1'b0;
  logic             move_valid;
  logic             move_ready = 1'b0;
  logic [5:0]       move_from;
  logic [5:0]       move_to;
  logic             gen_done;
  logic             pos_illegal;
  logic [CNT_W-1:0] move_count;
  logic [2:0]       state_mode;
  logic             wtm;
  logic [3:0]       write_bus;
  logic [5:0]       ss1;
  logic [1:0]       mask_mode;
  logic [6:0]       data_out = '0;
  logic             illegal = 1'b0;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
  } mv_t;
  mv_t exp_q[$];

  // Board model state, commands latched at the falling edge.
  logic [3:0] board [64];
  logic       vmask [64];
  logic       amask [64];
  logic [2:0] c_sm = '0;
  logic [1:0] c_mm = '0;
  logic [5:0] c_ss1 = '0;
  logic [3:0] c_wb = '0;

  always #5 clk = ~clk;

  move_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_sq(load_sq), .load_piece(load_piece),
    .gen_start(gen_start), .gen_wtm(gen_wtm), .gen_abort(gen_abort),
    .move_valid(move_valid), .move_ready(move_ready), .move_from(move_from), .move_to(move_to),
    .gen_done(gen_done), .pos_illegal(pos_illegal), .move_count(move_count),
    .state_mode(state_mode), .wtm(wtm), .write_bus(write_bus), .ss1(ss1), .mask_mode(mask_mode),
    .data_out(data_out), .illegal(illegal)
  );

  // Pseudo-legal attack test on the current board contents.
  function automatic logic attacks(input int from, input int to);
    int fr, ff, tr, tf, dr, df, sr, sf, r, f;
    logic [3:0] p;
    logic [2:0] t;
    p  = board[from];
    t  = p[2:0];
    fr = from / 8; ff = from % 8; tr = to / 8; tf = to % 8;
    dr = tr - fr;  df = tf - ff;
    if (from == to || t == 3'd0) return 1'b0;
    case (t)
      3'd1: return (df == 1 || df == -1) && (dr == (p[3] ? -1 : 1));
      3'd2: return (dr * dr + df * df) == 5;
      3'd6: return dr >= -1 && dr <= 1 && df >= -1 && df <= 1;
      default: begin
        if (dr == 0 || df == 0) begin
          if (t == 3'd3) return 1'b0;
        end else if (dr == df || dr == -df) begin
          if (t == 3'd4) return 1'b0;
        end else begin
          return 1'b0;
        end
        sr = (dr > 0) ? 1 : ((dr < 0) ? -1 : 0);
        sf = (df > 0) ? 1 : ((df < 0) ? -1 : 0);
        r = fr + sr; f = ff + sf;
        while (r != tr || f != tf) begin
          if (board[r * 8 + f] != 4'h0) return 1'b0;
          r += sr; f += sf;
        end
        return 1'b1;
      end
    endcase
  endfunction

  // Board query answers: most valuable victim, least valuable attacker, own-king check.
  always @(negedge clk) begin : board_query
    logic own;
    logic [2:0] bt;
    own      = ~wtm;
    data_out = '0;
    illegal  = 1'b0;
    c_sm  = state_mode;
    c_mm  = mask_mode;
    c_ss1 = ss1;
    c_wb  = write_bus;
    if (state_mode == SM_VICTIM) begin
      bt = 3'd0;
      for (int s = 0; s < 64; s++)
        if (board[s][2:0] != 3'd0 && board[s][2:0] != 3'd6 && board[s][3] != own &&
            !vmask[s] && board[s][2:0] > bt) begin
          bt = board[s][2:0];
          data_out = {1'b1, 6'(s)};
        end
    end else if (state_mode == SM_AGGR) begin
      bt = 3'd7;
      for (int s = 0; s < 64; s++)
        if (board[s][2:0] != 3'd0 && board[s][3] == own && !amask[s] &&
            attacks(s, int'(ss1)) && board[s][2:0] < bt) begin
          bt = board[s][2:0];
          data_out = {1'b1, 6'(s)};
        end
    end else if (state_mode == SM_CHECK) begin
      for (int k = 0; k < 64; k++)
        if (board[k] == {own, 3'd6})
          for (int s = 0; s < 64; s++)
            if (board[s] != 4'h0 && board[s][3] != own && attacks(s, k)) illegal = 1'b1;
    end
  end

  // Board writes and mask updates commit on the rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 64; s++) begin
        board[s] <= 4'h0;
        vmask[s] <= 1'b0;
        amask[s] <= 1'b0;
      end
    end else begin
      if (c_sm == SM_WRITE) board[c_ss1] <= c_wb;
      case (c_mm)
        MK_AGGR: amask[c_ss1] <= 1'b1;
        MK_VICTIM: begin
          vmask[c_ss1] <= 1'b1;
          for (int s = 0; s < 64; s++) amask[s] <= 1'b0;
        end
        MK_CLEAR:
          for (int s = 0; s < 64; s++) begin
            vmask[s] <= 1'b0;
            amask[s] <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  // Scoreboard: every accepted move must be the next expected capture.
  always @(negedge clk) begin : move_monitor
    mv_t e;
    if (rst_n && gen_done) done_cnt++;
    if (rst_n && move_valid && move_ready) begin
      hs_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL move_unexpected: got %0d->%0d, required no move", move_from, move_to);
      end else begin
        e = exp_q.pop_front();
        if ({move_from, move_to} !== {e.from, e.to}) begin
          fails++;
          $display("FAIL move_order: got %0d->%0d, required %0d->%0d", move_from, move_to, e.from, e.to);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] sq, input logic [3:0] p);
    load_valid = 1'b1; load_sq = sq; load_piece = p;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic clear_board();
    for (int s = 0; s < 64; s++) load(6'(s), PC_EMPTY);
  endtask

  task automatic start_pass(input logic side);
    gen_start = 1'b1; gen_wtm = side;
    tick();
    gen_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = move_valid;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = move_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b1; load_sq = 6'd5; load_piece = 4'h3;
    tick(); tick();
    tests++;
    if ({load_ready, move_valid, gen_done, pos_illegal, wtm} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 00000", {load_ready, move_valid, gen_done, pos_illegal, wtm});
    end
    tests++;
    if ({state_mode, mask_mode, ss1, write_bus, move_count, move_from, move_to} !== '0) begin
      fails++;
      $display("FAIL reset_buses: got sm=%0d mk=%0d ss1=%0d wb=%0d cnt=%0d, required all 0",
               state_mode, mask_mode, ss1, write_bus, move_count);
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++;
    if (load_ready !== 1'b1 || state_mode !== 3'(SM_IDLE)) begin
      fails++;
      $display("FAIL reset_idle: got load_ready=%b sm=%0d, required 1/0", load_ready, state_mode);
    end
  endtask

  task automatic test_load_priority();
    load_valid = 1'b1; load_sq = 6'd10; load_piece = PC_PAWN;
    gen_start = 1'b1; gen_wtm = 1'b1;
    #1;
    tests++;
    if (state_mode !== 3'(SM_WRITE) || ss1 !== 6'd10 || write_bus !== PC_PAWN) begin
      fails++;
      $display("FAIL load_write_cmd: got sm=%0d ss1=%0d wb=%0d, required 1/10/1", state_mode, ss1, write_bus);
    end
    tick();
    load_valid = 1'b0; gen_start = 1'b0;
    #1;
    tests++;
    if (load_ready !== 1'b1 || state_mode !== 3'(SM_IDLE)) begin
      fails++;
      $display("FAIL load_wins: got load_ready=%b sm=%0d, required 1/0", load_ready, state_mode);
    end
  endtask

  task automatic test_single_capture();
    int d0, h0;
    bit ok;
    clear_board();
    load(6'd3, PC_ROOK);
    load(6'd59, PC_BLACK | PC_QUEEN);
    exp_q.push_back('{from: 6'd3, to: 6'd59});
    move_ready = 1'b1;
    d0 = done_cnt; h0 = hs_cnt;
    start_pass(1'b1);
    tests++;
    if (wtm !== 1'b1 || state_mode !== 3'(SM_CHECK)) begin
      fails++;
      $display("FAIL single_check_cmd: got wtm=%b sm=%0d, required 1/2", wtm, state_mode);
    end
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no gen_done, required one"); end
    tests++;
    if (move_count !== 8'd1 || hs_cnt - h0 != 1 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL single_counts: got count=%0d hs=%0d done=%0d, required 1/1/1",
               move_count, hs_cnt - h0, done_cnt - d0);
    end
    tests++;
    if (pos_illegal !== 1'b0 || load_ready !== 1'b1 || wtm !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: got illegal=%b load_ready=%b wtm=%b, required 0/1/0", pos_illegal, load_ready, wtm);
    end
  endtask

  task automatic test_mvv_order();
    bit ok;
    clear_board();
    load(6'd36, PC_BLACK | PC_QUEEN);
    load(6'd48, PC_BLACK | PC_PAWN);
    load(6'd19, PC_KNIGHT);
    load(6'd0, PC_ROOK);
    exp_q.push_back('{from: 6'd19, to: 6'd36});
    exp_q.push_back('{from: 6'd0, to: 6'd48});
    start_pass(1'b1);
    wait_done(ok);
    tests++;
    if (!ok || move_count !== 8'd2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mvv_result: got done=%b count=%0d pending=%0d, required 1/2/0", ok, move_count, exp_q.size());
    end
  endtask

  task automatic test_lva_order();
    bit ok;
    clear_board();
    load(6'd36, PC_BLACK | PC_ROOK);
    load(6'd19, PC_KNIGHT);
    load(6'd4, PC_QUEEN);
    exp_q.push_back('{from: 6'd19, to: 6'd36});
    exp_q.push_back('{from: 6'd4, to: 6'd36});
    start_pass(1'b1);
    wait_done(ok);
    tests++;
    if (!ok || move_count !== 8'd2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL lva_result: got done=%b count=%0d pending=%0d, required 1/2/0", ok, move_count, exp_q.size());
    end
  endtask

  task automatic test_black_to_move();
    bit ok;
    clear_board();
    load(6'd36, PC_QUEEN);
    load(6'd19, PC_BLACK | PC_KNIGHT);
    exp_q.push_back('{from: 6'd19, to: 6'd36});
    start_pass(1'b0);
    tests++;
    if (wtm !== 1'b0) begin fails++; $display("FAIL black_wtm: got %b, required 0", wtm); end
    wait_done(ok);
    tests++;
    if (!ok || move_count !== 8'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL black_result: got done=%b count=%0d pending=%0d, required 1/1/0", ok, move_count, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int h0;
    bit ok;
    clear_board();
    load(6'd3, PC_ROOK);
    load(6'd59, PC_BLACK | PC_QUEEN);
    exp_q.push_back('{from: 6'd3, to: 6'd59});
    move_ready = 1'b0;
    h0 = hs_cnt;
    start_pass(1'b1);
    wait_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hold_timeout: got no move_valid, required assertion"); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (move_valid !== 1'b1 || move_from !== 6'd3 || move_to !== 6'd59 || move_count !== 8'd0 || wtm !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got v=%b %0d->%0d cnt=%0d wtm=%b, required 1 3->59 0 1",
                 i, move_valid, move_from, move_to, move_count, wtm);
      end
    end
    move_ready = 1'b1;
    tick();
    tests++;
    if (move_valid !== 1'b0 || move_count !== 8'd1 || hs_cnt - h0 != 1 || mask_mode !== 2'(MK_AGGR)) begin
      fails++;
      $display("FAIL hold_accept: got v=%b cnt=%0d hs=%0d mk=%0d, required 0/1/1/1",
               move_valid, move_count, hs_cnt - h0, mask_mode);
    end
    wait_done(ok);
    tests++;
    if (!ok || move_count !== 8'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL hold_result: got done=%b count=%0d pending=%0d, required 1/1/0", ok, move_count, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    int d0, h0;
    bit ok;
    clear_board();
    load(6'd4, PC_KING);
    load(6'd60, PC_BLACK | PC_ROOK);
    load(6'd43, PC_KNIGHT);
    d0 = done_cnt; h0 = hs_cnt;
    start_pass(1'b1);
    wait_done(ok);
    tests++;
    if (!ok || pos_illegal !== 1'b1 || move_count !== 8'd0 || hs_cnt != h0 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL illegal_result: got done=%b illegal=%b cnt=%0d hs=%0d pulses=%0d, required 1/1/0/0/1",
               ok, pos_illegal, move_count, hs_cnt - h0, done_cnt - d0);
    end
    tick(); tick();
    tests++;
    if (pos_illegal !== 1'b1) begin fails++; $display("FAIL illegal_hold: got %b, required 1", pos_illegal); end
  endtask

  task automatic test_abort();
    int d0, h0;
    bit ok;
    clear_board();
    load(6'd3, PC_ROOK);
    load(6'd59, PC_BLACK | PC_QUEEN);
    move_ready = 1'b0;
    d0 = done_cnt; h0 = hs_cnt;
    start_pass(1'b1);
    wait_valid(ok);
    tests++;
    if (!ok || pos_illegal !== 1'b0) begin
      fails++;
      $display("FAIL abort_setup: got valid=%b illegal=%b, required 1/0", ok, pos_illegal);
    end
    gen_abort = 1'b1; move_ready = 1'b1;
    #1;
    tests++;
    if (move_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b, required 0", move_valid); end
    tick();
    gen_abort = 1'b0; move_ready = 1'b0;
    tests++;
    if (mask_mode !== 2'(MK_CLEAR) || move_valid !== 1'b0 || load_ready !== 1'b0 || gen_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear: got mk=%0d v=%b lr=%b done=%b, required 3/0/0/0", mask_mode, move_valid, load_ready, gen_done);
    end
    tick();
    tests++;
    if (mask_mode !== 2'(MK_NONE) || load_ready !== 1'b1 || move_count !== 8'd0 || hs_cnt != h0 || done_cnt != d0) begin
      fails++;
      $display("FAIL abort_idle: got mk=%0d lr=%b cnt=%0d hs=%0d pulses=%0d, required 0/1/0/0/0",
               mask_mode, load_ready, move_count, hs_cnt - h0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_load_priority();
    test_single_capture();
    test_mvv_order();
    test_lva_order();
    test_black_to_move();
    test_backpressure();
    test_illegal();
    test_abort();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending moves, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
